// File: rtl/axil_reg_bank_if.sv
// AXI4-Lite bus bundle for the register bank.
// 32-bit address and data, 4-bit write strobe.
interface axil_reg_bank_if;
  logic [31:0] awaddr;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;
  logic [31:0] araddr;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;

  modport master (
    output awaddr, awvalid, wdata, wstrb, wvalid,
    output bready, araddr, arvalid, rready,
    input  awready, wready, bresp, bvalid,
    input  arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awvalid, wdata, wstrb, wvalid,
    input  bready, araddr, arvalid, rready,
    output awready, wready, bresp, bvalid,
    output arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/axil_reg_bank.sv
// AXI4-Lite register bank: R/W control words, RO status words
// and saturating clear-on-read event counters.
module axil_reg_bank #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int NUM_RW    = 4,
  parameter int NUM_RO    = 4,
  parameter int NUM_CNT   = 4,
  parameter int CNT_WIDTH = 32,
  parameter logic [32*NUM_RW-1:0] RW_DEFAULT = '0
) (
  input  logic                  clk,
  input  logic                  resetn,
  axil_reg_bank_if.slave        s_axi,
  output logic [32*NUM_RW-1:0]  rw_reg,
  output logic [NUM_RW-1:0]     rw_wr_pulse,
  input  logic [32*NUM_RO-1:0]  ro_reg,
  input  logic [NUM_CNT-1:0]    cnt_evt
);
  localparam int RO_LO = NUM_RW;
  localparam int CN_LO = NUM_RW + NUM_RO;
  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;

  logic [31:0]          r_rw [NUM_RW];
  logic [CNT_WIDTH-1:0] r_cnt [NUM_CNT];

  logic        r_aw_held;
  logic [31:0] r_aw_addr;
  logic        r_w_held;
  logic [31:0] r_w_data;
  logic [3:0]  r_w_strb;
  logic        r_bvalid;
  logic [1:0]  r_bresp;
  logic [NUM_RW-1:0] r_wr_pulse;

  logic        r_rvalid;
  logic [31:0] r_rdata;
  logic [1:0]  r_rresp;

  logic [31:0] w_awk;
  logic [31:0] w_ark;
  logic        w_aw_hs;
  logic        w_w_hs;
  logic        w_ar_hs;
  logic        w_do_wr;
  logic        w_aw_rw;
  logic [31:0] w_rdata;
  logic [1:0]  w_rresp;
  logic [NUM_CNT-1:0] w_cnt_clr;

  assign s_axi.awready = ~r_aw_held & ~r_bvalid;
  assign s_axi.wready  = ~r_w_held & ~r_bvalid;
  assign s_axi.bvalid  = r_bvalid;
  assign s_axi.bresp   = r_bresp;
  assign s_axi.arready = ~r_rvalid;
  assign s_axi.rvalid  = r_rvalid;
  assign s_axi.rdata   = r_rdata;
  assign s_axi.rresp   = r_rresp;
  assign rw_wr_pulse   = r_wr_pulse;

  for (genvar g = 0; g < NUM_RW; g++) begin : g_out
    assign rw_reg[32*g +: 32] = r_rw[g];
  end

  assign w_aw_hs = s_axi.awvalid & s_axi.awready;
  assign w_w_hs  = s_axi.wvalid & s_axi.wready;
  assign w_ar_hs = s_axi.arvalid & s_axi.arready;
  assign w_do_wr = r_aw_held & r_w_held;

  // Word index; the byte offset within a word is discarded.
  assign w_awk   = (r_aw_addr - BASE_ADDR) >> 2;
  assign w_ark   = (s_axi.araddr - BASE_ADDR) >> 2;
  assign w_aw_rw = w_awk < 32'(NUM_RW);

  always_comb begin
    w_rdata   = 32'hDEAD_BEEF;
    w_rresp   = SLVERR;
    w_cnt_clr = '0;
    for (int i = 0; i < NUM_RW; i++) begin
      if (w_ark == i) begin
        w_rdata = r_rw[i];
        w_rresp = OKAY;
      end
    end
    for (int i = 0; i < NUM_RO; i++) begin
      if (w_ark == RO_LO + i) begin
        w_rdata = ro_reg[32*i +: 32];
        w_rresp = OKAY;
      end
    end
    for (int i = 0; i < NUM_CNT; i++) begin
      if (w_ark == CN_LO + i) begin
        w_rdata      = 32'(r_cnt[i]);
        w_rresp      = OKAY;
        w_cnt_clr[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_aw_held  <= 1'b0;
      r_aw_addr  <= '0;
      r_w_held   <= 1'b0;
      r_w_data   <= '0;
      r_w_strb   <= '0;
      r_bvalid   <= 1'b0;
      r_bresp    <= OKAY;
      r_wr_pulse <= '0;
      for (int i = 0; i < NUM_RW; i++)
        r_rw[i] <= RW_DEFAULT[32*i +: 32];
    end else begin
      r_wr_pulse <= '0;
      if (w_aw_hs) begin
        r_aw_held <= 1'b1;
        r_aw_addr <= s_axi.awaddr;
      end
      if (w_w_hs) begin
        r_w_held <= 1'b1;
        r_w_data <= s_axi.wdata;
        r_w_strb <= s_axi.wstrb;
      end
      if (w_do_wr) begin
        r_aw_held <= 1'b0;
        r_w_held  <= 1'b0;
        r_bvalid  <= 1'b1;
        r_bresp   <= w_aw_rw ? OKAY : SLVERR;
        for (int i = 0; i < NUM_RW; i++) begin
          if (w_awk == i) begin
            r_wr_pulse[i] <= 1'b1;
            for (int j = 0; j < 4; j++)
              if (r_w_strb[j])
                r_rw[i][8*j +: 8] <= r_w_data[8*j +: 8];
          end
        end
      end else if (r_bvalid && s_axi.bready) begin
        r_bvalid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_rvalid <= 1'b0;
      r_rdata  <= '0;
      r_rresp  <= OKAY;
    end else if (w_ar_hs) begin
      r_rvalid <= 1'b1;
      r_rdata  <= w_rdata;
      r_rresp  <= w_rresp;
    end else if (r_rvalid && s_axi.rready) begin
      r_rvalid <= 1'b0;
    end
  end

  // A clear coinciding with an event leaves 1 so the event is kept.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_CNT; i++) begin
      if (!resetn)
        r_cnt[i] <= '0;
      else if (w_ar_hs && w_cnt_clr[i])
        r_cnt[i] <= CNT_WIDTH'(cnt_evt[i]);
      else if (cnt_evt[i] && (r_cnt[i] != {CNT_WIDTH{1'b1}}))
        r_cnt[i] <= r_cnt[i] + 1'b1;
    end
  end
endmodule

// File: tb/tb_axil_reg_bank.sv
// Randomised self-checking bench for axil_reg_bank
// against a word-level model of the register map.
module tb_axil_reg_bank;
  localparam logic [127:0] DEF =
    {32'hCAFE_0003, 32'h0, 32'h0, 32'h1234_5678};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         resetn;
  logic [127:0] rw_reg;
  logic [3:0]   pulse;
  logic [127:0] ro_in;
  logic [3:0]   evt;
  logic [127:0] rw_reg4;
  logic [3:0]   pulse4;
  logic [3:0]   evt4;

  axil_reg_bank_if bus ();
  axil_reg_bank_if bus4 ();

  axil_reg_bank #(.RW_DEFAULT(DEF)) dut (
    .clk(clk), .resetn(resetn), .s_axi(bus),
    .rw_reg(rw_reg), .rw_wr_pulse(pulse),
    .ro_reg(ro_in), .cnt_evt(evt)
  );

  axil_reg_bank #(.CNT_WIDTH(4)) dut4 (
    .clk(clk), .resetn(resetn), .s_axi(bus4),
    .rw_reg(rw_reg4), .rw_wr_pulse(pulse4),
    .ro_reg(ro_in), .cnt_evt(evt4)
  );

  int cmp_cnt = 0;
  int err_cnt = 0;
  logic [31:0] m_rw [4];
  longint      m_cnt [4];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_bus();
    bus.awvalid = 0; bus.wvalid = 0; bus.bready = 0;
    bus.arvalid = 0; bus.rready = 0;
    bus.awaddr = 0; bus.wdata = 0; bus.wstrb = 0; bus.araddr = 0;
    bus4.awvalid = 0; bus4.wvalid = 0; bus4.bready = 0;
    bus4.arvalid = 0; bus4.rready = 0;
    bus4.awaddr = 0; bus4.wdata = 0; bus4.wstrb = 0; bus4.araddr = 0;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      m_rw[i] = DEF[32*i +: 32];
      m_cnt[i] = 0;
    end
  endtask

  function automatic logic [127:0] model_rw();
    logic [127:0] v;
    for (int i = 0; i < 4; i++) v[32*i +: 32] = m_rw[i];
    return v;
  endfunction

  task automatic axi_write(input logic [31:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, output logic [1:0] resp,
                           output logic [3:0] pv);
    bit awh, wh, got;
    int n;
    bus.awaddr = addr; bus.awvalid = 1;
    bus.wdata = data; bus.wstrb = strb; bus.wvalid = 1;
    got = 0; n = 0; resp = 2'bxx; pv = 4'bxxxx;
    while (!got && n < 30) begin
      awh = bus.awvalid && bus.awready;
      wh = bus.wvalid && bus.wready;
      tick(); n++;
      if (awh) bus.awvalid = 0;
      if (wh) bus.wvalid = 0;
      if (bus.bvalid) begin
        got = 1; resp = bus.bresp; pv = pulse;
      end
    end
    bus.awvalid = 0; bus.wvalid = 0;
    cmp_cnt++;
    if (!got) begin
      err_cnt++;
      $display("FAIL wr_timeout addr=%h: no BVALID in 30 cycles", addr);
    end
    bus.bready = 1; tick(); bus.bready = 0;
  endtask

  task automatic axi_read(input logic [31:0] addr, output logic [31:0] data,
                          output logic [1:0] resp, output bit lat_ok);
    bit hs;
    int n;
    bus.araddr = addr; bus.arvalid = 1;
    hs = 0; n = 0;
    while (!hs && n < 30) begin
      hs = bus.arvalid && bus.arready;
      tick(); n++;
    end
    bus.arvalid = 0;
    lat_ok = hs && bus.rvalid;
    data = bus.rdata; resp = bus.rresp;
    bus.rready = 1; tick(); bus.rready = 0;
  endtask

  task automatic read4(input logic [31:0] addr, output logic [31:0] data,
                       output bit lat_ok);
    bit hs;
    int n;
    bus4.araddr = addr; bus4.arvalid = 1;
    hs = 0; n = 0;
    while (!hs && n < 30) begin
      hs = bus4.arvalid && bus4.arready;
      tick(); n++;
    end
    bus4.arvalid = 0;
    lat_ok = hs && bus4.rvalid;
    data = bus4.rdata;
    bus4.rready = 1; tick(); bus4.rready = 0;
  endtask

  task automatic do_reset();
    resetn = 0; idle_bus(); evt = 0; evt4 = 0;
    repeat (3) tick();
    resetn = 1;
    tick();
    model_reset();
  endtask

  task automatic test_reset();
    logic [31:0] d; logic [1:0] r; bit ok;
    do_reset();
    cmp_cnt++;
    if (rw_reg !== DEF || pulse !== 4'b0) begin
      err_cnt++;
      $display("FAIL rst_rw got=%h/%b want=%h/0", rw_reg, pulse, DEF);
    end
    cmp_cnt++;
    if ({bus.awready, bus.wready, bus.arready, bus.bvalid, bus.rvalid}
        !== 5'b11100) begin
      err_cnt++;
      $display("FAIL rst_hs got=%b want=11100",
        {bus.awready, bus.wready, bus.arready, bus.bvalid, bus.rvalid});
    end
    cmp_cnt++;
    if (bus.bresp !== 2'b0 || bus.rresp !== 2'b0 || bus.rdata !== 32'h0) begin
      err_cnt++;
      $display("FAIL rst_resp got=%b/%b/%h want=0/0/0",
        bus.bresp, bus.rresp, bus.rdata);
    end
    cmp_cnt++;
    if (rw_reg4 !== 128'h0 || pulse4 !== 4'h0 || bus4.arready !== 1'b1) begin
      err_cnt++;
      $display("FAIL rst_dut4 got=%h/%b/%b want=0/0/1",
        rw_reg4, pulse4, bus4.arready);
    end
    axi_read(32'h0, d, r, ok);
    cmp_cnt++;
    if (d !== 32'h1234_5678 || r !== 2'b00 || !ok) begin
      err_cnt++;
      $display("FAIL rd_default got=%h/%b lat=%0d want=12345678/00 lat=1",
        d, r, ok);
    end
  endtask

  task automatic test_w_before_aw();
    bus.wdata = 32'hAABB_CCDD; bus.wstrb = 4'b0101; bus.wvalid = 1;
    tick();
    bus.wvalid = 0;
    cmp_cnt++;
    if (bus.wready !== 1'b0 || bus.awready !== 1'b1) begin
      err_cnt++;
      $display("FAIL w_held got wr=%b awr=%b want 0/1",
        bus.wready, bus.awready);
    end
    tick(); tick();
    cmp_cnt++;
    if (bus.bvalid !== 1'b0) begin
      err_cnt++;
      $display("FAIL early_b got=%b want=0", bus.bvalid);
    end
    bus.awaddr = 32'h4; bus.awvalid = 1;
    tick();
    bus.awvalid = 0;
    tick();
    m_rw[1] = 32'h00BB_00DD;
    cmp_cnt++;
    if (bus.bvalid !== 1'b1 || bus.bresp !== 2'b00 || pulse !== 4'b0010
        || rw_reg[63:32] !== 32'h00BB_00DD) begin
      err_cnt++;
      $display("FAIL wr_strb got b=%b r=%b p=%b w1=%h want 1/00/0010/00bb00dd",
        bus.bvalid, bus.bresp, pulse, rw_reg[63:32]);
    end
    for (int i = 0; i < 5; i++) begin
      tick();
      cmp_cnt++;
      if ({bus.bvalid, bus.awready, bus.wready, pulse} !== 7'b1000000) begin
        err_cnt++;
        $display("FAIL b_hold cyc=%0d got=%b want=1000000", i,
          {bus.bvalid, bus.awready, bus.wready, pulse});
      end
    end
    bus.bready = 1; tick(); bus.bready = 0;
    cmp_cnt++;
    if ({bus.bvalid, bus.awready, bus.wready} !== 3'b011) begin
      err_cnt++;
      $display("FAIL b_done got=%b want=011",
        {bus.bvalid, bus.awready, bus.wready});
    end
  endtask

  task automatic test_slverr();
    logic [1:0] r; logic [3:0] p; logic [31:0] d; bit ok;
    ro_in = {$urandom, $urandom, $urandom, $urandom};
    axi_write(32'h10, 32'h1111_2222, 4'hF, r, p);
    cmp_cnt++;
    if (r !== 2'b10 || p !== 4'b0) begin
      err_cnt++;
      $display("FAIL wr_ro got=%b/%b want=10/0000", r, p);
    end
    axi_write(32'd800, 32'h3333_4444, 4'hF, r, p);
    cmp_cnt++;
    if (r !== 2'b10 || p !== 4'b0) begin
      err_cnt++;
      $display("FAIL wr_unmap got=%b/%b want=10/0000", r, p);
    end
    cmp_cnt++;
    if (rw_reg !== model_rw()) begin
      err_cnt++;
      $display("FAIL err_nochg got=%h want=%h", rw_reg, model_rw());
    end
    axi_read(32'h10, d, r, ok);
    cmp_cnt++;
    if (d !== ro_in[31:0] || r !== 2'b00 || !ok) begin
      err_cnt++;
      $display("FAIL rd_ro got=%h/%b want=%h/00", d, r, ro_in[31:0]);
    end
    axi_read(32'h20, d, r, ok);
    cmp_cnt++;
    if (d !== 32'h0 || r !== 2'b00 || !ok) begin
      err_cnt++;
      $display("FAIL rd_cnt_idle got=%h/%b want=0/00", d, r);
    end
    axi_read(32'd800, d, r, ok);
    cmp_cnt++;
    if (d !== 32'hDEAD_BEEF || r !== 2'b10 || !ok) begin
      err_cnt++;
      $display("FAIL rd_unmap got=%h/%b want=deadbeef/10", d, r);
    end
  endtask

  task automatic test_counter();
    logic [31:0] d; logic [1:0] r; bit ok;
    evt[0] = 1; repeat (10) tick(); evt[0] = 0;
    axi_read(32'h20, d, r, ok);
    cmp_cnt++;
    if (d !== 32'd10 || r !== 2'b00) begin
      err_cnt++;
      $display("FAIL cnt10 got=%0d/%b want=10/00", d, r);
    end
    axi_read(32'h20, d, r, ok);
    cmp_cnt++;
    if (d !== 32'd0) begin
      err_cnt++;
      $display("FAIL cnt_clr got=%0d want=0", d);
    end
    evt[0] = 1; repeat (3) tick();
    bus.araddr = 32'h20; bus.arvalid = 1;
    tick();
    bus.arvalid = 0; evt[0] = 0;
    cmp_cnt++;
    if (bus.rvalid !== 1'b1 || bus.rdata !== 32'd3) begin
      err_cnt++;
      $display("FAIL cnt_race got v=%b d=%0d want 1/3", bus.rvalid, bus.rdata);
    end
    bus.rready = 1; tick(); bus.rready = 0;
    axi_read(32'h20, d, r, ok);
    cmp_cnt++;
    if (d !== 32'd1) begin
      err_cnt++;
      $display("FAIL cnt_keep got=%0d want=1", d);
    end
  endtask

  task automatic test_saturate();
    logic [31:0] d; bit ok;
    evt4[0] = 1; repeat (20) tick(); evt4[0] = 0;
    read4(32'h20, d, ok);
    cmp_cnt++;
    if (d !== 32'd15 || !ok) begin
      err_cnt++;
      $display("FAIL cnt_sat got=%0d want=15", d);
    end
    read4(32'h20, d, ok);
    cmp_cnt++;
    if (d !== 32'd0) begin
      err_cnt++;
      $display("FAIL cnt_sat_clr got=%0d want=0", d);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] nv, old; logic [31:0] d; logic [1:0] r; bit ok;
    old = m_rw[2];
    nv = $urandom;
    bus.awaddr = 32'h8; bus.awvalid = 1;
    bus.wdata = nv; bus.wstrb = 4'hF; bus.wvalid = 1;
    tick();
    bus.awvalid = 0; bus.wvalid = 0;
    bus.araddr = 32'h8; bus.arvalid = 1;
    tick();
    bus.arvalid = 0;
    cmp_cnt++;
    if (bus.rvalid !== 1'b1 || bus.bvalid !== 1'b1 || bus.rdata !== old) begin
      err_cnt++;
      $display("FAIL rw_same got rv=%b bv=%b d=%h want 1/1/%h",
        bus.rvalid, bus.bvalid, bus.rdata, old);
    end
    bus.rready = 1; bus.bready = 1; tick();
    bus.rready = 0; bus.bready = 0;
    m_rw[2] = nv;
    axi_read(32'h8, d, r, ok);
    cmp_cnt++;
    if (d !== nv || r !== 2'b00) begin
      err_cnt++;
      $display("FAIL rw_after got=%h want=%h", d, nv);
    end
  endtask

  task automatic test_random();
    logic [31:0] d, ed, data, a; logic [1:0] r, er; logic [3:0] p, ep, s;
    bit ok;
    int k, c, n;
    for (int it = 0; it < 60; it++) begin
      ro_in = {$urandom, $urandom, $urandom, $urandom};
      c = $urandom_range(0, 3);
      n = $urandom_range(0, 5);
      evt[c] = 1; repeat (n) tick(); evt[c] = 0;
      m_cnt[c] += n;
      k = ($urandom_range(0, 7) == 0) ? $urandom_range(12, 4000)
                                      : $urandom_range(0, 11);
      a = 32'(k) * 4 + 32'($urandom_range(0, 3));
      if ($urandom_range(0, 1) == 1) begin
        data = $urandom; s = 4'($urandom);
        axi_write(a, data, s, r, p);
        er = (k < 4) ? 2'b00 : 2'b10;
        ep = (k < 4) ? 4'(1 << k) : 4'b0;
        if (k < 4)
          for (int j = 0; j < 4; j++)
            if (s[j]) m_rw[k][8*j +: 8] = data[8*j +: 8];
        cmp_cnt++;
        if (r !== er || p !== ep || rw_reg !== model_rw()) begin
          err_cnt++;
          $display("FAIL rnd_wr k=%0d got=%b/%b/%h want=%b/%b/%h",
            k, r, p, rw_reg, er, ep, model_rw());
        end
      end else begin
        axi_read(a, d, r, ok);
        er = 2'b00;
        if (k < 4) ed = m_rw[k];
        else if (k < 8) ed = ro_in[32*(k-4) +: 32];
        else if (k < 12) begin
          ed = 32'(m_cnt[k-8]); m_cnt[k-8] = 0;
        end else begin
          ed = 32'hDEAD_BEEF; er = 2'b10;
        end
        cmp_cnt++;
        if (d !== ed || r !== er || !ok) begin
          err_cnt++;
          $display("FAIL rnd_rd k=%0d got=%h/%b/%0d want=%h/%b/1",
            k, d, r, ok, ed, er);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] d, nv; logic [1:0] r; logic [3:0] p; bit ok;
    bus.awaddr = 32'hC; bus.awvalid = 1;
    bus.wdata = 32'h5555_AAAA; bus.wstrb = 4'hF; bus.wvalid = 1;
    tick();
    bus.awvalid = 0; bus.wvalid = 0;
    tick();
    bus.araddr = 32'h0; bus.arvalid = 1;
    tick();
    bus.araddr = 32'h4;
    tick();
    cmp_cnt++;
    if ({bus.bvalid, bus.rvalid, bus.arready} !== 3'b110) begin
      err_cnt++;
      $display("FAIL mid_pend got=%b want=110",
        {bus.bvalid, bus.rvalid, bus.arready});
    end
    resetn = 0;
    tick();
    cmp_cnt++;
    if ({bus.bvalid, bus.rvalid, bus.awready, bus.arready} !== 4'b0011
        || rw_reg !== DEF) begin
      err_cnt++;
      $display("FAIL mid_rst got=%b rw=%h want=0011 rw=%h",
        {bus.bvalid, bus.rvalid, bus.awready, bus.arready}, rw_reg, DEF);
    end
    bus.arvalid = 0;
    resetn = 1;
    tick();
    model_reset();
    nv = $urandom;
    axi_write(32'hC, nv, 4'hF, r, p);
    cmp_cnt++;
    if (r !== 2'b00 || p !== 4'b1000) begin
      err_cnt++;
      $display("FAIL post_wr got=%b/%b want=00/1000", r, p);
    end
    m_rw[3] = nv;
    axi_read(32'hC, d, r, ok);
    cmp_cnt++;
    if (d !== nv || r !== 2'b00 || !ok) begin
      err_cnt++;
      $display("FAIL post_rd got=%h/%b want=%h/00", d, r, nv);
    end
  endtask

  initial begin
    ro_in = '0;
    test_reset();
    test_w_before_aw();
    test_slverr();
    test_counter();
    test_saturate();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
      cmp_cnt, err_cnt);
    $finish;
  end
endmodule

// File: doc/axil_reg_bank.md
Name: axil_reg_bank

Overview:
Parametrised AXI4-Lite register bank for management-plane control and status, generalising the fixed per-design CPU register block. It provides NUM_RW read/write control registers, NUM_RO read-only status inputs and NUM_CNT internal clear-on-read event counters. It decouples the AW and W channels and returns SLVERR on illegal accesses. It sits between the AXI-Lite interconnect and the datapath, on the datapath clock.

Parameters:
BASE_ADDR, 32'h0000_0000, byte base address of the bank; offsets are computed as S_AXI_*ADDR - BASE_ADDR.
NUM_RW, 4, number of 32-bit R/W registers (1..64).
NUM_RO, 4, number of 32-bit read-only status words (1..64).
NUM_CNT, 4, number of clear-on-read event counters (1..64).
CNT_WIDTH, 32, counter width (1..32); the value is zero-extended on read.
RW_DEFAULT, {NUM_RW{32'h0}}, flattened reset values for the R/W registers.

Ports:
clk  in  1  clock; also clocks the AXI-Lite interface.
resetn  in  1  synchronous, active-low reset.
rw_reg  out  32*NUM_RW  R/W register contents; word i is at bits [32i+31:32i].
rw_wr_pulse  out  NUM_RW  1-cycle strobe, asserted the cycle after register i is written.
ro_reg  in  32*NUM_RO  status words, sampled at read acceptance.
cnt_evt  in  NUM_CNT  event pulses; each cycle high increments counter i by 1.
S_AXI_AWADDR/AWVALID/AWREADY, S_AXI_WDATA/WSTRB/WVALID/WREADY, S_AXI_BRESP/BVALID/BREADY, S_AXI_ARADDR/ARVALID/ARREADY, S_AXI_RDATA/RRESP/RVALID/RREADY: standard AXI4-Lite, 32-bit address, 32-bit data, 4-bit strobe.

Behaviour:
- Address map (word index k = offset>>2; offset[1:0] ignored):
  - k in [0, NUM_RW): R/W registers.
  - k in [NUM_RW, NUM_RW+NUM_RO): RO words.
  - k in [NUM_RW+NUM_RO, NUM_RW+NUM_RO+NUM_CNT): counters.
  - All other k: unmapped.
- Reset values:
  - rw_reg = RW_DEFAULT; counters = 0; rw_wr_pulse = 0.
  - AWREADY = WREADY = ARREADY = 1.
  - BVALID = RVALID = 0; BRESP = RRESP = 0; RDATA = 0.
- Write channel:
  - AW and W are each held in a one-entry buffer.
  - AWREADY = ~aw_held & ~BVALID; WREADY = ~w_held & ~BVALID.
  - AW and W may arrive in either order, or together in the same cycle.
  - In the cycle both buffers are full, the write is performed. Next cycle: BVALID=1, both buffers emptied.
  - BVALID holds until BREADY. AWREADY/WREADY return to 1 the cycle after the B handshake.
  - R/W target: byte lane j is updated only where WSTRB[j]=1; BRESP=OKAY; rw_wr_pulse[k] fires for 1 cycle, coincident with BVALID rising.
  - RO, counter or unmapped target: no state change; BRESP=SLVERR (2'b10).
  - WSTRB=0 to an R/W target: no lane change, BRESP=OKAY, pulse still fires.
- Read channel:
  - ARREADY = ~RVALID. On the AR handshake, the next cycle drives RVALID=1 with RDATA/RRESP.
  - RVALID and RDATA are stable until RREADY. ARREADY is 1 again the cycle after the R handshake.
  - R/W target: current register value. RO target: ro_reg word sampled in the AR handshake cycle. Both OKAY.
  - Counter target: counter value in the AR handshake cycle, zero-extended. The counter is cleared in the same edge.
  - Unmapped target: RDATA=32'hDEADBEEF, RRESP=SLVERR.
- Counters:
  - Saturate at 2^CNT_WIDTH-1; no wrap-around.
  - If an event and a clear-on-read occur in the same cycle, the counter becomes 1, so no event is lost. The read returns the pre-increment value.
- Concurrency:
  - Read and write channels are independent; both may complete in the same cycle.
  - A write and a read to the same R/W register in the same cycle: the read returns the old value.
- resetn low mid-transaction:
  - Abandons held AW/W and pending B/R.
  - All outputs return to their reset values on the next edge; no B or R is issued for abandoned transfers.

Test Plan:
1. Reset, then read k=0 with RW_DEFAULT word0=32'h1234_5678 -> RDATA=32'h1234_5678, RRESP=0, RVALID exactly 1 cycle after the AR handshake.
2. W (data 32'hAABBCCDD, WSTRB=4'b0101) issued 3 cycles before AW to k=1, where register 1 holds 0 -> rw_reg word1=32'h00BB00DD; BVALID with OKAY; rw_wr_pulse[1] high 1 cycle; AWREADY/WREADY stay low while BREADY is held low for 5 cycles.
3. Write to the first RO index and to index 200 -> both BRESP=SLVERR, ro/counter state unchanged. Read index 200 -> RDATA=32'hDEADBEEF, RRESP=2'b10.
4. Counter 0:
   - Drive 10 cnt_evt[0] pulses, then read -> 10. Immediate re-read -> 0.
   - Read in a cycle with cnt_evt[0]=1 -> returns the prior value; next read returns 1.
5. CNT_WIDTH=4, drive 20 events -> read returns 15 (saturated), then 0 on re-read.
6. Assert resetn low while BVALID pending and AR held -> BVALID=RVALID=0 next edge; rw_reg returns to RW_DEFAULT; a subsequent clean write/read completes normally.
